// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle HI/LO divider.
package div_pkg;

    localparam int unsigned REG_BUS_W        = 32;
    localparam int unsigned DOUBLE_REG_BUS_W = 64;
    localparam int unsigned WORK_W           = 2 * REG_BUS_W + 1;
    localparam int unsigned CNT_W            = 6;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(REG_BUS_W);

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Two's-complement magnitude of a 32-bit word (0x80000000 maps to itself).
    function automatic logic [REG_BUS_W-1:0] abs32(input logic [REG_BUS_W-1:0] v);
        return v[REG_BUS_W-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_if.sv
// EX <-> divider request/result bundle. master = EX stage, slave = divider.
interface div_if;
    import div_pkg::*;

    logic                          signed_div_i;
    logic [REG_BUS_W-1:0]          opdata1_i;
    logic [REG_BUS_W-1:0]          opdata2_i;
    logic                          start_i;
    logic                          annul_i;
    logic [DOUBLE_REG_BUS_W-1:0]   result_o;
    logic                          ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/div.sv
// Restoring radix-2 32-bit divider, one quotient bit per cycle.
// result_o = {remainder, quotient}; divide-by-zero returns 0 after two edges.
// Optional macro DIV_SIGNED_EN: honour signed_div_i (abs on input, sign fixup
// on output). Without it every operation is unsigned.
module div
    import div_pkg::*;
(
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);

    div_state_e                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [WORK_W-1:0]           work_q, work_d;
    logic [REG_BUS_W-1:0]        divisor_q, divisor_d;
    logic [DOUBLE_REG_BUS_W-1:0] result_q, result_d;
    logic                        ready_q, ready_d;

    logic                        accept;
    logic                        div_zero;
    logic [REG_BUS_W-1:0]        dividend_abs;
    logic [REG_BUS_W-1:0]        divisor_abs;
    logic                        borrow;
    logic [REG_BUS_W-1:0]        diff;
    logic [WORK_W-1:0]           work_step;
    logic [REG_BUS_W-1:0]        quot_fix;
    logic [REG_BUS_W-1:0]        rem_fix;

    assign div_zero = (bus.opdata2_i == '0);
    assign accept   = (state_q == DivFree) && bus.start_i && !bus.annul_i;

`ifdef DIV_SIGNED_EN
    logic neg_quot_q, neg_quot_d;
    logic neg_rem_q, neg_rem_d;

    // Operand magnitudes for signed requests.
    always_comb begin
        dividend_abs = bus.signed_div_i ? abs32(bus.opdata1_i) : bus.opdata1_i;
        divisor_abs  = bus.signed_div_i ? abs32(bus.opdata2_i) : bus.opdata2_i;
    end

    // Remember which result halves need negating once iteration finishes.
    always_comb begin
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        if (accept && !div_zero) begin
            neg_quot_d = bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
            neg_rem_d  = bus.signed_div_i && bus.opdata1_i[31];
        end
    end

    // Sign flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    // Sign fixup: quotient negative when signs differ, remainder follows dividend.
    always_comb begin
        quot_fix = neg_quot_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
        rem_fix  = neg_rem_q ? (~work_q[64:33] + 32'd1) : work_q[64:33];
    end
`else
    logic unused_signed_div;
    assign unused_signed_div = bus.signed_div_i;

    // Unsigned-only build: operands and results pass straight through.
    always_comb begin
        dividend_abs = bus.opdata1_i;
        divisor_abs  = bus.opdata2_i;
        quot_fix     = work_q[31:0];
        rem_fix      = work_q[64:33];
    end
`endif

    // One restoring step. The partial remainder is compared as the 33-bit
    // window work_q[64:32] (already shifted by one), so divisors above 2^31
    // are handled; when no borrow occurs the true difference fits in 32 bits.
    always_comb begin
        borrow    = (work_q[64:32] < {1'b0, divisor_q});
        diff      = work_q[63:32] - divisor_q;
        if (borrow) begin
            work_step = {work_q[63:0], 1'b0};
        end else begin
            work_step = {diff, work_q[31:0], 1'b1};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DivFree: begin
                if (accept) begin
                    state_d = div_zero ? DivByZero : DivOn;
                end
            end
            DivByZero: state_d = DivEnd;
            DivOn: begin
                if (bus.annul_i) begin
                    state_d = DivFree;
                end else if (cnt_q == LAST_STEP) begin
                    state_d = DivEnd;
                end
            end
            DivEnd: begin
                if (bus.start_i == DivStop) begin
                    state_d = DivFree;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    // Datapath and registered outputs per state.
    always_comb begin
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        result_d  = result_q;
        ready_d   = ready_q;
        case (state_q)
            DivFree: begin
                ready_d  = DivResultNotReady;
                result_d = '0;
                if (accept && !div_zero) begin
                    divisor_d = divisor_abs;
                    work_d    = {32'b0, dividend_abs, 1'b0};
                    cnt_d     = '0;
                end
            end
            DivByZero: begin
                result_d = '0;
                ready_d  = DivResultReady;
            end
            DivOn: begin
                if (bus.annul_i) begin
                    cnt_d    = '0;
                    work_d   = '0;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else if (cnt_q == LAST_STEP) begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = DivResultReady;
                end else begin
                    work_d = work_step;
                    cnt_d  = cnt_q + 6'd1;
                end
            end
            DivEnd: begin
                ready_d = DivResultReady;
                if (bus.start_i == DivStop) begin
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end
            end
            default: begin
                ready_d  = DivResultNotReady;
                result_d = '0;
            end
        endcase
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule
